// File: rtl/stage2_memory_access_pkg.sv
// Shared constants for the memory-access stage: word width, default depth and select encodings.
// Build option: STAGE2_MEM_INIT_EN selects the memory preload pattern (see dual_port_ram).
package stage2_memory_access_pkg;

  localparam int WORD_BITS         = 16;
  localparam int DEFAULT_ADDR_BITS = 10;

  typedef logic [WORD_BITS-1:0] word_t;

  // Port-1 address select; any other code addresses word 0
  localparam logic [1:0] DST1_FROM_PC  = 2'd0;
  localparam logic [1:0] DST1_FROM_MSP = 2'd1;

  // Port-2 address select; any other code addresses word 0
  localparam logic [1:0] DST2_FROM_MSP = 2'd0;
  localparam logic [1:0] DST2_FROM_RSP = 2'd1;

  // Shared write-data select; any other code writes 0x0000
  localparam logic [2:0] DATA_FROM_PC    = 3'd0;
  localparam logic [2:0] DATA_FROM_RES   = 3'd1;
  localparam logic [2:0] DATA_FROM_ZEIMM = 3'd2;

endpackage

// File: rtl/stage2_memory_access_if.sv
// Bus bundle between the stage-2 control/address sources and the memory-access stage.
interface stage2_memory_access_if;
  import stage2_memory_access_pkg::*;

  word_t      MemDst1FromPC;
  word_t      MemDst1FromMSP;
  word_t      MemDst2FromMSP;
  word_t      MemDst2FromRSP;
  word_t      MemDataFromPC;
  word_t      MemDataFromRes;
  word_t      MemDataFromZEImm;
  logic [1:0] MemDst1;
  logic [1:0] MemDst2;
  logic [2:0] MemData;
  logic       MemRead1;
  logic       MemRead2;
  logic       MemWrite1;
  logic       MemWrite2;
  logic       IRWrite;
  logic       ValAWrite;
  logic       ValBWrite;
  word_t      IR;
  word_t      ValA;
  word_t      ValB;

  modport master (
    output MemDst1FromPC, MemDst1FromMSP, MemDst2FromMSP, MemDst2FromRSP,
    output MemDataFromPC, MemDataFromRes, MemDataFromZEImm,
    output MemDst1, MemDst2, MemData,
    output MemRead1, MemRead2, MemWrite1, MemWrite2,
    output IRWrite, ValAWrite, ValBWrite,
    input  IR, ValA, ValB
  );

  modport slave (
    input  MemDst1FromPC, MemDst1FromMSP, MemDst2FromMSP, MemDst2FromRSP,
    input  MemDataFromPC, MemDataFromRes, MemDataFromZEImm,
    input  MemDst1, MemDst2, MemData,
    input  MemRead1, MemRead2, MemWrite1, MemWrite2,
    input  IRWrite, ValAWrite, ValBWrite,
    output IR, ValA, ValB
  );

endinterface

// File: rtl/stage2_memory_access_dual_port_ram.sv
// Dual-port read-first word RAM with registered reads and a shared write-data input.
// Build option: STAGE2_MEM_INIT_EN preloads mem[i] = i mod 10; otherwise the RAM powers up zeroed.
module dual_port_ram
  import stage2_memory_access_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [ADDR_BITS-1:0] addr1,
  input  logic [ADDR_BITS-1:0] addr2,
  input  word_t                writeData,
  input  logic                 read1,
  input  logic                 read2,
  input  logic                 write1,
  input  logic                 write2,
  output word_t                readData1,
  output word_t                readData2
);

  localparam int DEPTH = 1 << ADDR_BITS;

  function automatic logic [DEPTH-1:0][WORD_BITS-1:0] buildImage();
    logic [DEPTH-1:0][WORD_BITS-1:0] image;
    image = '0;
`ifdef STAGE2_MEM_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      image[i] = WORD_BITS'(i % 10);
    end
`endif
    return image;
  endfunction

  logic [DEPTH-1:0][WORD_BITS-1:0] mem = buildImage();

  // Port 1 is written last so it wins a same-address collision; contents survive reset
  always_ff @(posedge CLK) begin
    if (write2) begin
      mem[addr2] <= writeData;
    end
    if (write1) begin
      mem[addr1] <= writeData;
    end
  end

  // Reads sample pre-edge contents, giving read-first behaviour on both ports
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      readData1 <= '0;
      readData2 <= '0;
    end else begin
      if (read1) begin
        readData1 <= mem[addr1];
      end
      if (read2) begin
        readData2 <= mem[addr2];
      end
    end
  end

endmodule

// File: rtl/stage2_memory_access.sv
// Memory-access stage: address/write-data muxes, dual-port RAM and the IR/ValA/ValB registers.
// Build option: STAGE2_MEM_INIT_EN (handled inside dual_port_ram) selects the RAM preload.
module stage2_memory_access
  import stage2_memory_access_pkg::*;
#(
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS
) (
  input logic                   CLK,
  input logic                   RST_N,
  stage2_memory_access_if.slave memBus
);

  logic [ADDR_BITS-1:0] addr1;
  logic [ADDR_BITS-1:0] addr2;
  word_t                writeData;
  word_t                readData1;
  word_t                readData2;
  word_t                irReg;
  word_t                valAReg;
  word_t                valBReg;

  // Only the low ADDR_BITS of each address candidate reach the RAM
  always_comb begin
    addr1 = '0;
    addr2 = '0;
    writeData = '0;
    case (memBus.MemDst1)
      DST1_FROM_PC:  addr1 = memBus.MemDst1FromPC[ADDR_BITS-1:0];
      DST1_FROM_MSP: addr1 = memBus.MemDst1FromMSP[ADDR_BITS-1:0];
      default:       addr1 = '0;
    endcase
    case (memBus.MemDst2)
      DST2_FROM_MSP: addr2 = memBus.MemDst2FromMSP[ADDR_BITS-1:0];
      DST2_FROM_RSP: addr2 = memBus.MemDst2FromRSP[ADDR_BITS-1:0];
      default:       addr2 = '0;
    endcase
    case (memBus.MemData)
      DATA_FROM_PC:    writeData = memBus.MemDataFromPC;
      DATA_FROM_RES:   writeData = memBus.MemDataFromRes;
      DATA_FROM_ZEIMM: writeData = memBus.MemDataFromZEImm;
      default:         writeData = '0;
    endcase
  end

  generate
    if (ADDR_BITS < WORD_BITS) begin : gUnusedAddr
      logic unusedAddrBits;
      assign unusedAddrBits = ^{memBus.MemDst1FromPC[WORD_BITS-1:ADDR_BITS],
                                memBus.MemDst1FromMSP[WORD_BITS-1:ADDR_BITS],
                                memBus.MemDst2FromMSP[WORD_BITS-1:ADDR_BITS],
                                memBus.MemDst2FromRSP[WORD_BITS-1:ADDR_BITS]};
    end
  endgenerate

  dual_port_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) ram (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .addr1     (addr1),
    .addr2     (addr2),
    .writeData (writeData),
    .read1     (memBus.MemRead1),
    .read2     (memBus.MemRead2),
    .write1    (memBus.MemWrite1),
    .write2    (memBus.MemWrite2),
    .readData1 (readData1),
    .readData2 (readData2)
  );

  // Second pipeline stage: IR and ValB both tap port 1, ValA taps port 2
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      irReg   <= '0;
      valAReg <= '0;
      valBReg <= '0;
    end else begin
      if (memBus.IRWrite) begin
        irReg <= readData1;
      end
      if (memBus.ValAWrite) begin
        valAReg <= readData2;
      end
      if (memBus.ValBWrite) begin
        valBReg <= readData1;
      end
    end
  end

  assign memBus.IR   = irReg;
  assign memBus.ValA = valAReg;
  assign memBus.ValB = valBReg;

endmodule

// File: tb/tb_stage2_memory_access.sv
// Self-checking bench for stage2_memory_access: directed steps then random traffic against a word-level model.
module tb_stage2_memory_access;
  import stage2_memory_access_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [1:0]  dst1;
    logic [1:0]  dst2;
    logic [2:0]  dataSel;
    logic [15:0] pc;
    logic [15:0] msp1;
    logic [15:0] msp2;
    logic [15:0] rsp;
    logic [15:0] dataPc;
    logic [15:0] res;
    logic [15:0] imm;
    logic        read1;
    logic        read2;
    logic        write1;
    logic        write2;
    logic        irW;
    logic        aW;
    logic        bW;
  } stim_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  stage2_memory_access_if memBus ();

  stage2_memory_access #(
    .ADDR_BITS (10)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .memBus (memBus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] modelMem [DEPTH];
  logic [15:0] modelRd1, modelRd2, modelIr, modelValA, modelValB;
  int assertCount = 0;
  int failCount = 0;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge CLK);
    memBus.MemDst1          = s.dst1;
    memBus.MemDst2          = s.dst2;
    memBus.MemData          = s.dataSel;
    memBus.MemDst1FromPC    = s.pc;
    memBus.MemDst1FromMSP   = s.msp1;
    memBus.MemDst2FromMSP   = s.msp2;
    memBus.MemDst2FromRSP   = s.rsp;
    memBus.MemDataFromPC    = s.dataPc;
    memBus.MemDataFromRes   = s.res;
    memBus.MemDataFromZEImm = s.imm;
    memBus.MemRead1         = s.read1;
    memBus.MemRead2         = s.read2;
    memBus.MemWrite1        = s.write1;
    memBus.MemWrite2        = s.write2;
    memBus.IRWrite          = s.irW;
    memBus.ValAWrite        = s.aW;
    memBus.ValBWrite        = s.bW;
  endtask

  function automatic int modelAddr1();
    case (memBus.MemDst1)
      2'd0:    return int'(memBus.MemDst1FromPC) % DEPTH;
      2'd1:    return int'(memBus.MemDst1FromMSP) % DEPTH;
      default: return 0;
    endcase
  endfunction

  function automatic int modelAddr2();
    case (memBus.MemDst2)
      2'd0:    return int'(memBus.MemDst2FromMSP) % DEPTH;
      2'd1:    return int'(memBus.MemDst2FromRSP) % DEPTH;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] modelWriteData();
    case (memBus.MemData)
      3'd0:    return memBus.MemDataFromPC;
      3'd1:    return memBus.MemDataFromRes;
      3'd2:    return memBus.MemDataFromZEImm;
      default: return 16'h0000;
    endcase
  endfunction

  // One rising edge: advance the model from the pre-edge inputs, then compare all outputs
  task automatic clockAndCheck(input string tag);
    int a1, a2;
    logic [15:0] wd, nRd1, nRd2;
    @(posedge CLK);
    if (RST_N) begin
      a1 = modelAddr1();
      a2 = modelAddr2();
      wd = modelWriteData();
      nRd1 = memBus.MemRead1 ? modelMem[a1] : modelRd1;
      nRd2 = memBus.MemRead2 ? modelMem[a2] : modelRd2;
      if (memBus.IRWrite)   modelIr   = modelRd1;
      if (memBus.ValBWrite) modelValB = modelRd1;
      if (memBus.ValAWrite) modelValA = modelRd2;
      modelRd1 = nRd1;
      modelRd2 = nRd2;
      if (memBus.MemWrite2) modelMem[a2] = wd;
      if (memBus.MemWrite1) modelMem[a1] = wd;
    end
    #1;
    checkOutput({tag, " IR"}, memBus.IR, modelIr);
    checkOutput({tag, " ValA"}, memBus.ValA, modelValA);
    checkOutput({tag, " ValB"}, memBus.ValB, modelValB);
  endtask

  task automatic resetModelRegs();
    modelRd1 = '0;
    modelRd2 = '0;
    modelIr = '0;
    modelValA = '0;
    modelValB = '0;
  endtask

  initial begin
    stim_t s;
    logic [15:0] oldMem7;

    for (int i = 0; i < DEPTH; i++) begin
`ifdef STAGE2_MEM_INIT_EN
      modelMem[i] = 16'(i % 10);
`else
      modelMem[i] = 16'h0000;
`endif
    end
    resetModelRegs();

    s = '{default: '0};
    applyStimulus(s);
    clockAndCheck("reset hold");
    clockAndCheck("reset hold");
    @(negedge CLK);
    RST_N = 1'b1;

    // Preload walk: PC steps down, MSP steps up every two cycles
    s = '{default: '0};
    s.read1 = 1'b1; s.read2 = 1'b1; s.irW = 1'b1; s.aW = 1'b1;
    for (int step = 0; step < 6; step++) begin
      s.pc = 16'(19 - step);
      s.msp2 = 16'(5 + step);
      applyStimulus(s);
      clockAndCheck("walk");
      clockAndCheck("walk");
    end

    // Write 0xBEEF through port 1 at MSP=40, then read it back into ValB
    s = '{default: '0};
    s.dataSel = 3'd1; s.res = 16'hBEEF; s.dst1 = 2'd1; s.msp1 = 16'd40; s.write1 = 1'b1;
    applyStimulus(s);
    clockAndCheck("write");
    s.write1 = 1'b0; s.read1 = 1'b1; s.bW = 1'b1;
    applyStimulus(s);
    clockAndCheck("readback");
    clockAndCheck("readback");
    checkOutput("readback ValB const", memBus.ValB, 16'hBEEF);

    // Read-first on port 1 at address 7
    oldMem7 = modelMem[7];
    s = '{default: '0};
    s.dataSel = 3'd1; s.res = 16'h1234; s.dst1 = 2'd1; s.msp1 = 16'd7;
    s.write1 = 1'b1; s.read1 = 1'b1; s.irW = 1'b1;
    applyStimulus(s);
    clockAndCheck("readfirst");
    s.write1 = 1'b0;
    applyStimulus(s);
    clockAndCheck("readfirst old");
    checkOutput("readfirst IR old", memBus.IR, oldMem7);
    clockAndCheck("readfirst new");
    checkOutput("readfirst IR new", memBus.IR, 16'h1234);

    // Seed distinct words at 20..22 through port 2 using the ZEImm source
    s = '{default: '0};
    s.dataSel = 3'd2; s.write2 = 1'b1;
    for (int a = 20; a <= 22; a++) begin
      s.msp2 = 16'(a);
      s.imm = 16'(a * 257);
      applyStimulus(s);
      clockAndCheck("seed");
    end

    s = '{default: '0};
    s.msp2 = 16'd20; s.read2 = 1'b1; s.aW = 1'b1;
    applyStimulus(s);
    clockAndCheck("enable load");
    clockAndCheck("enable load");
    checkOutput("enable ValA 20", memBus.ValA, 16'h1414);
    s.aW = 1'b0; s.msp2 = 16'd21;
    applyStimulus(s);
    clockAndCheck("ValA hold");
    clockAndCheck("ValA hold");
    checkOutput("ValA hold const", memBus.ValA, 16'h1414);
    s.read2 = 1'b0; s.msp2 = 16'd22;
    applyStimulus(s);
    clockAndCheck("RD2 hold");
    s.aW = 1'b1;
    applyStimulus(s);
    clockAndCheck("RD2 hold");
    checkOutput("RD2 hold ValA", memBus.ValA, 16'h1515);

    // Unused selects: address 0 for codes 2/3, zero data for codes 3..7
    s = '{default: '0};
    s.dst1 = 2'd1; s.dataSel = 3'd1; s.write1 = 1'b1;
    s.msp1 = 16'd0; s.res = 16'hA5A5;
    applyStimulus(s);
    clockAndCheck("seed zero");
    s.msp1 = 16'd3; s.res = 16'h3333;
    applyStimulus(s);
    clockAndCheck("seed three");
    s.dataSel = 3'd5; s.res = 16'h7777;
    applyStimulus(s);
    clockAndCheck("data sel 5");
    s = '{default: '0};
    s.dst2 = 2'd2; s.msp2 = 16'd3; s.rsp = 16'd3; s.read2 = 1'b1; s.aW = 1'b1;
    s.dst1 = 2'd3; s.pc = 16'd5; s.msp1 = 16'd6; s.read1 = 1'b1; s.irW = 1'b1;
    applyStimulus(s);
    clockAndCheck("sel unused");
    clockAndCheck("sel unused");
    checkOutput("dst2=2 ValA", memBus.ValA, 16'hA5A5);
    checkOutput("dst1=3 IR", memBus.IR, 16'hA5A5);
    s.dst2 = 2'd1;
    applyStimulus(s);
    clockAndCheck("zeroed word");
    clockAndCheck("zeroed word");
    checkOutput("mem3 zeroed", memBus.ValA, 16'h0000);

    // Asynchronous reset mid-cycle, no edge needed
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    resetModelRegs();
    checkOutput("async reset IR", memBus.IR, 16'h0000);
    checkOutput("async reset ValA", memBus.ValA, 16'h0000);
    checkOutput("async reset ValB", memBus.ValB, 16'h0000);
    @(negedge CLK);
    RST_N = 1'b1;

    // Random traffic over a small address window with junk in the unused upper bits
    for (int n = 0; n < 400; n++) begin
      s.dst1 = 2'($urandom_range(0, 3));
      s.dst2 = 2'($urandom_range(0, 3));
      s.dataSel = 3'($urandom_range(0, 7));
      s.pc = 16'($urandom) & 16'hFC0F;
      s.msp1 = 16'($urandom) & 16'hFC0F;
      s.msp2 = 16'($urandom) & 16'hFC0F;
      s.rsp = 16'($urandom) & 16'hFC0F;
      s.dataPc = 16'($urandom);
      s.res = 16'($urandom);
      s.imm = 16'($urandom);
      s.read1 = 1'($urandom);
      s.read2 = 1'($urandom);
      s.write1 = 1'($urandom);
      s.write2 = 1'($urandom);
      s.irW = 1'($urandom);
      s.aW = 1'($urandom);
      s.bW = 1'($urandom);
      applyStimulus(s);
      clockAndCheck("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
